// File: rtl/erx_dispatcher_pkg.sv
// Shared emesh packet layout and the RX destination decode used by the dispatcher.
package erx_dispatcher_pkg;

  localparam int EM_WRITE     = 0;
  localparam int EM_DMODE_LSB = 1;
  localparam int EM_CTRL_LSB  = 3;
  localparam int EM_DST_LSB   = 8;
  // dstaddr[31:20] carries the routing ID
  localparam int EM_DST_HI_LSB = EM_DST_LSB + 20;
  localparam int NDEST        = 4;

  typedef enum logic [1:0] {
    DST_WR  = 2'd0,
    DST_RD  = 2'd1,
    DST_RR  = 2'd2,
    DST_CFG = 2'd3
  } dest_e;

  function automatic int emesh_pw(input int aw);
    return 2 * aw + 40;
  endfunction

  function automatic int emesh_data_lsb(input int aw);
    return EM_DST_LSB + aw;
  endfunction

  function automatic int emesh_src_lsb(input int aw);
    return EM_DST_LSB + aw + 32;
  endfunction

  // Config space wins over everything, then read responses, then plain writes.
  function automatic dest_e emesh_decode(input logic write, input logic [11:0] hi,
                                         input logic [11:0] id, input logic [11:0] rr_id);
    if (hi == id)                return DST_CFG;
    else if (write && hi == rr_id) return DST_RR;
    else if (write)              return DST_WR;
    else                         return DST_RD;
  endfunction

endpackage

// File: rtl/erx_dispatcher_if.sv
// RX ingress plus the four per-destination valid/packet/wait channels.
interface erx_dispatcher_if #(parameter int PW = 104);
  logic          erx_access;
  logic [PW-1:0] erx_packet;
  logic          erx_wait;
  logic          rxwr_access, rxrd_access, rxrr_access, cfg_access;
  logic [PW-1:0] rxwr_packet, rxrd_packet, rxrr_packet, cfg_packet;
  logic          rxwr_wait, rxrd_wait, rxrr_wait, cfg_wait;

  modport slave (
    input  erx_access, erx_packet,
    output erx_wait,
    output rxwr_access, rxrd_access, rxrr_access, cfg_access,
    output rxwr_packet, rxrd_packet, rxrr_packet, cfg_packet,
    input  rxwr_wait, rxrd_wait, rxrr_wait, cfg_wait
  );

  modport master (
    output erx_access, erx_packet,
    input  erx_wait,
    input  rxwr_access, rxrd_access, rxrr_access, cfg_access,
    input  rxwr_packet, rxrd_packet, rxrr_packet, cfg_packet,
    output rxwr_wait, rxrd_wait, rxrr_wait, cfg_wait
  );
endinterface

// File: rtl/erx_dispatch_buf.sv
// Two-entry FIFO; dout is the oldest entry and is only meaningful while count != 0.
module erx_dispatch_buf #(
  parameter int DW = 104
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [1:0]    count,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Push into a full buffer with a same-cycle pop reuses the slot being read out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && !pop && count == 2'd2));
      assert (!(pop && count == 2'd0));
    end
  end

endmodule

// File: rtl/erx_dispatcher.sv
// Routes accepted RX packets by class into per-destination 2-deep buffers.
module erx_dispatcher
  import erx_dispatcher_pkg::*;
#(
  parameter int          AW    = 32,
  parameter int          PW    = emesh_pw(AW),
  parameter logic [11:0] ID    = 12'h000,
  parameter logic [11:0] RR_ID = 12'h800
) (
  input  logic            clk,
  input  logic            reset,
  erx_dispatcher_if.slave bus
);

  logic                       erx_wait_q, erx_wait_d;
  logic                       accept;
  dest_e                      dst;
  logic [NDEST-1:0]           push, pop, dst_vld, dst_wait;
  logic [NDEST-1:0][1:0]      cnt, cnt_nxt;
  logic [NDEST-1:0][PW-1:0]   dout;

  assign accept = bus.erx_access & ~erx_wait_q;
  assign dst    = emesh_decode(bus.erx_packet[EM_WRITE], bus.erx_packet[EM_DST_HI_LSB +: 12],
                               ID, RR_ID);

  assign dst_wait = {bus.cfg_wait, bus.rxrr_wait, bus.rxrd_wait, bus.rxwr_wait};

  for (genvar g = 0; g < NDEST; g++) begin : g_dst
    assign push[g]    = accept && (dst == dest_e'(g));
    assign dst_vld[g] = (cnt[g] != 2'd0);
    assign pop[g]     = dst_vld[g] & ~dst_wait[g];
    assign cnt_nxt[g] = cnt[g] + {1'b0, push[g]} - {1'b0, pop[g]};

    erx_dispatch_buf #(.DW(PW)) u_buf (
      .clk   (clk),
      .reset (reset),
      .push  (push[g]),
      .din   (bus.erx_packet),
      .pop   (pop[g]),
      .count (cnt[g]),
      .dout  (dout[g])
    );
  end

  // Look one cycle ahead: a stalled destination holding anything, or a full one,
  // must stop the next accept because erx_wait is itself a register.
  always_comb begin
    erx_wait_d = 1'b0;
    for (int i = 0; i < NDEST; i++)
      erx_wait_d |= (cnt_nxt[i] == 2'd2) | ((cnt_nxt[i] != 2'd0) & dst_wait[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) erx_wait_q <= 1'b0;
    else       erx_wait_q <= erx_wait_d;
  end

  assign bus.erx_wait    = erx_wait_q;
  assign bus.rxwr_access = dst_vld[DST_WR];
  assign bus.rxrd_access = dst_vld[DST_RD];
  assign bus.rxrr_access = dst_vld[DST_RR];
  assign bus.cfg_access  = dst_vld[DST_CFG];
  assign bus.rxwr_packet = dout[DST_WR];
  assign bus.rxrd_packet = dout[DST_RD];
  assign bus.rxrr_packet = dout[DST_RR];
  assign bus.cfg_packet  = dout[DST_CFG];

endmodule

// File: tb/tb_erx_dispatcher.sv
// Directed + random bench for erx_dispatcher with per-class scoreboard queues.
module tb_erx_dispatcher;
  localparam int AW = 32;
  localparam int PW = 104;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  erx_dispatcher_if #(.PW(PW)) bus();

  erx_dispatcher #(.AW(AW), .PW(PW), .ID(12'h000), .RR_ID(12'h800)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int            n_vec = 0;
  int            n_err = 0;
  logic [PW-1:0] sb [4][$];
  logic          rand_waits = 1'b0;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // 0=wr 1=rd 2=rr 3=cfg
  function automatic int cls(input logic [PW-1:0] p);
    logic [11:0] hi;
    hi = p[39:28];
    if (hi == 12'h000)            return 3;
    if (p[0] && hi == 12'h800)    return 2;
    if (p[0])                     return 0;
    return 1;
  endfunction

  function automatic logic [PW-1:0] mk(input logic wr, input logic [31:0] dst,
                                       input logic [31:0] data, input logic [31:0] src);
    return {src, data, dst, 5'h03, 2'b10, wr};
  endfunction

  function automatic logic [3:0] acc_vec();
    return {bus.cfg_access, bus.rxrr_access, bus.rxrd_access, bus.rxwr_access};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Holds erx_access until a cycle where erx_wait was low at the edge.
  task automatic send(input logic [PW-1:0] p);
    logic ok;
    ok = 1'b0;
    bus.erx_access = 1'b1;
    bus.erx_packet = p;
    for (int k = 0; k < 200 && !ok; k++) begin
      ok = !bus.erx_wait;
      @(posedge clk); #1;
    end
    bus.erx_access = 1'b0;
    chk("send_accepted", ok, 1'b1);
  endtask

  task automatic drain();
    int left;
    left = 1;
    for (int k = 0; k < 400 && left != 0; k++) begin
      left = sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size();
      if (left != 0) wait_cyc(1);
    end
    chk("drain_empty", left, 0);
  endtask

  // Scoreboard: pops happen at the next edge when access && !wait.
  always @(negedge clk) begin : mon
    logic [3:0]    acc, wt;
    logic [PW-1:0] pk [4];
    if (!reset) begin
      acc = acc_vec();
      wt  = {bus.cfg_wait, bus.rxrr_wait, bus.rxrd_wait, bus.rxwr_wait};
      pk[0] = bus.rxwr_packet; pk[1] = bus.rxrd_packet;
      pk[2] = bus.rxrr_packet; pk[3] = bus.cfg_packet;
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && !wt[i]) begin
          if (sb[i].size() == 0) chk($sformatf("spurious_out%0d", i), acc[i], 1'b0);
          else                   chk($sformatf("order_dst%0d", i), pk[i], sb[i].pop_front());
        end
      end
      if (bus.erx_access && !bus.erx_wait) sb[cls(bus.erx_packet)].push_back(bus.erx_packet);
    end
  end

  always @(posedge clk) begin
    if (rand_waits) begin
      #1;
      {bus.cfg_wait, bus.rxrr_wait, bus.rxrd_wait, bus.rxwr_wait} = 4'($urandom);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] a, b, c;
    logic [11:0]   hi;
    int            sel;

    bus.erx_access = 1'b0;
    bus.erx_packet = '0;
    {bus.cfg_wait, bus.rxrr_wait, bus.rxrd_wait, bus.rxwr_wait} = 4'b0;
    reset = 1'b1;
    wait_cyc(3);
    chk("rst_access", acc_vec(), 4'b0);
    chk("rst_erx_wait", bus.erx_wait, 1'b0);
    reset = 1'b0;

    // plain write -> rxwr next cycle
    a = mk(1'b1, 32'h8100_0040, 32'hDEAD_BEEF, 32'h1234_5678);
    send(a);
    chk("wr_access", bus.rxwr_access, 1'b1);
    chk("wr_packet", bus.rxwr_packet, a);
    chk("wr_others", {bus.cfg_access, bus.rxrr_access, bus.rxrd_access}, 3'b0);
    drain();

    // read to own ID -> cfg, write to RR_ID -> rxrr
    a = mk(1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_0001);
    send(a);
    chk("cfg_access", bus.cfg_access, 1'b1);
    chk("cfg_not_rd", bus.rxrd_access, 1'b0);
    chk("cfg_packet", bus.cfg_packet, a);
    a = mk(1'b1, 32'h8000_0000, 32'h5555_AAAA, 32'hCAFE_0002);
    send(a);
    chk("rr_access", bus.rxrr_access, 1'b1);
    chk("rr_not_wr", bus.rxwr_access, 1'b0);
    chk("rr_packet", bus.rxrr_packet, a);
    drain();

    // rxwr stalls after first accept: two buffered, third held off
    a = mk(1'b1, 32'h1000_0000, 32'h0000_00A1, 32'h0);
    b = mk(1'b1, 32'h1000_0004, 32'h0000_00B2, 32'h0);
    c = mk(1'b1, 32'h1000_0008, 32'h0000_00C3, 32'h0);
    send(a);
    bus.rxwr_wait = 1'b1;
    send(b);
    bus.erx_access = 1'b1;
    bus.erx_packet = c;
    for (int k = 0; k < 3; k++) begin
      chk("full_erx_wait", bus.erx_wait, 1'b1);
      chk("full_head", bus.rxwr_packet, a);
      wait_cyc(1);
    end
    bus.rxwr_wait = 1'b0;
    send(c);
    drain();

    // rxrd full and stalled; a pending write waits, then flows once rxrd drains
    a = mk(1'b0, 32'h2000_0000, 32'h0, 32'h0000_0011);
    b = mk(1'b0, 32'h2000_0010, 32'h0, 32'h0000_0022);
    c = mk(1'b1, 32'h3000_0000, 32'h7777_0000, 32'h0000_0033);
    send(a);
    bus.rxrd_wait = 1'b1;
    send(b);
    bus.erx_access = 1'b1;
    bus.erx_packet = c;
    for (int k = 0; k < 3; k++) begin
      chk("rd_stall_wait", bus.erx_wait, 1'b1);
      chk("rd_stall_head", bus.rxrd_packet, a);
      chk("rd_stall_wr_idle", bus.rxwr_access, 1'b0);
      wait_cyc(1);
    end
    bus.rxrd_wait = 1'b0;
    send(c);
    drain();

    // random mixed traffic with random destination stalls
    rand_waits = 1'b1;
    for (int n = 0; n < 100; n++) begin
      sel = $urandom_range(0, 3);
      hi  = (sel == 0) ? 12'h000 : (sel == 1) ? 12'h800 : 12'($urandom_range(1, 12'h7FF));
      send(mk(1'($urandom), {hi, 20'($urandom)}, $urandom, $urandom));
    end
    rand_waits = 1'b0;
    wait_cyc(1);
    {bus.cfg_wait, bus.rxrr_wait, bus.rxrd_wait, bus.rxwr_wait} = 4'b0;
    drain();

    // reset with two packets buffered discards them
    a = mk(1'b1, 32'h1100_0000, 32'h0000_0E01, 32'h0);
    b = mk(1'b1, 32'h1100_0004, 32'h0000_0E02, 32'h0);
    send(a);
    bus.rxwr_wait = 1'b1;
    send(b);
    reset = 1'b1;
    wait_cyc(1);
    chk("midrst_access", acc_vec(), 4'b0);
    chk("midrst_erx_wait", bus.erx_wait, 1'b0);
    for (int i = 0; i < 4; i++) sb[i].delete();
    bus.rxwr_wait = 1'b0;
    reset = 1'b0;
    c = mk(1'b1, 32'h1100_0100, 32'h0000_0F0F, 32'h0);
    send(c);
    chk("postrst_access", bus.rxwr_access, 1'b1);
    chk("postrst_packet", bus.rxwr_packet, c);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/erx_dispatcher.md
ERX_DISPATCHER -- requirements
Module: erx_dispatcher

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter PW, default 2*AW+40, emesh packet width (104 at AW=32).
REQ-003 SHALL have parameter ID, default 12'h000, link ID; dstaddr[31:20]==ID selects the config port.
REQ-004 SHALL have parameter RR_ID, default 12'h800; a write with dstaddr[31:20]==RR_ID is a read response.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 erx_access  in  1  incoming packet valid from RX pins.
REQ-008 erx_packet  in  PW  incoming emesh packet.
REQ-009 erx_wait  out  1  registered pushback to RX.
REQ-010 rxwr_access / rxrd_access / rxrr_access / cfg_access  out  1 each  per-destination valid.
REQ-011 rxwr_packet / rxrd_packet / rxrr_packet / cfg_packet  out  PW each  per-destination packet.
REQ-012 rxwr_wait / rxrd_wait / rxrr_wait / cfg_wait  in  1 each  per-destination stall.

Function
REQ-013 Packet fields SHALL be: write=[0], datamode=[2:1], ctrlmode=[7:3], dstaddr=[39:8], data=[71:40], srcaddr=[103:72].
REQ-014 Accept SHALL occur on a cycle with erx_access=1 and erx_wait=0; erx_access while erx_wait=1 is ignored (packet not captured).
REQ-015 Class decode, priority order: dstaddr[31:20]==ID -> cfg (read or write); else write=1 and dstaddr[31:20]==RR_ID -> rxrr; else write=1 -> rxwr; else -> rxrd.
REQ-016 Each destination SHALL own a 2-entry FIFO buffer; an accepted packet is pushed into exactly one buffer, unmodified.
REQ-017 <dest>_access SHALL be 1 whenever its buffer is non-empty; <dest>_packet SHALL present the oldest entry.
REQ-018 Pop SHALL occur on <dest>_access=1 and <dest>_wait=0; push and pop on the same buffer in one cycle SHALL leave count unchanged and keep order.
REQ-019 Latency: accept at cycle t -> <dest>_access=1 at t+1 when that buffer was empty.
REQ-020 Order within one class SHALL be preserved; no ordering is guaranteed across classes.
REQ-021 erx_wait SHALL be a register loaded each cycle with OR over destinations of (count_next==2) | (count_next>=1 & <dest>_wait).
REQ-022 No buffer SHALL overflow under any stimulus; a push into a full buffer is a design error flagged by an assertion.
REQ-023 Destinations SHALL be independent: a stalled destination blocks input only via erx_wait, never drains or corrupts another buffer.

Reset
REQ-024 While reset=1, all buffer counts and pointers SHALL clear, all <dest>_access=0, erx_wait=0 on the following edge.
REQ-025 Reset mid-operation SHALL discard buffered packets; packet data registers need no reset.
REQ-026 First accept SHALL be possible on the first cycle after reset deasserts.

Structure
REQ-027 Emesh packet field offsets and PW formula SHALL live in the shared emesh constants include used by TX and RX.
REQ-028 The 2-entry buffer SHALL be one sub-module, erx_dispatch_buf (parameter DW; push, pop, count, dout), instantiated four times.
REQ-029 Decode and erx_wait logic SHALL stay in erx_dispatcher.

Verification
REQ-030 Write, dstaddr=32'h8100_0040, all waits 0 -> rxwr_access=1 next cycle, packet identical, others 0.
REQ-031 Read (write=0), dstaddr=32'h0000_0010, ID=0 -> cfg_access=1, not rxrd; write to 32'h8000_0000 -> rxrr_access=1.
REQ-032 rxwr_wait=1, three back-to-back writes -> two buffered, erx_wait=1 blocks third; release wait -> both drain in order, third then accepted.
REQ-033 rxrd_wait=1 with full rxrd buffer; erx_wait=1 holds; rxwr buffer contents unaffected and drain normally.
REQ-034 Stream 100 random mixed packets, random waits -> per-class order and contents match scoreboard, no overflow assertion.
REQ-035 Assert reset with 2 packets buffered -> next cycle all *_access=0, erx_wait=0; post-reset packet delivered normally.
